// File: rtl/edca_backoff.sv
// EDCA channel-access engine: per-queue AIFS deferral, slot backoff and one-hot tx grant.
// Define EDCA_VIRTUAL_COLLISION_EN to make losing READY queues take the failure path.

module edca_queue #(
    parameter int CW_WIDTH   = 10,
    parameter int TIME_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  us_pulse,
    input  logic                  ch_idle,
    input  logic [TIME_WIDTH-1:0] idle_us,
    input  logic [TIME_WIDTH-1:0] aifs_us,
    input  logic [4:0]            slot_time,
    input  logic [3:0]            cw_min_exp,
    input  logic [3:0]            cw_max_exp,
    input  logic [CW_WIDTH-1:0]   rnd,
    input  logic                  start,
    input  logic                  result,
    input  logic                  result_ok,
    input  logic                  lose,
    output logic                  ready,
    output logic [3:0]            stage
);
    typedef enum logic [1:0] {DEFER, COUNT, READY, TXING} state_t;

    state_t              state;
    logic [CW_WIDTH-1:0] bo_cnt;
    logic [4:0]          slot_us;
    logic [3:0]          new_stage;
    logic [4:0]          e_eff;
    logic [CW_WIDTH-1:0] mask;
    logic [CW_WIDTH-1:0] draw;

    // The draw always uses the stage the queue is moving to (binary exponential growth).
    always_comb begin
        new_stage = (stage == 4'hf) ? stage : stage + 4'd1;
        if (state == TXING && result_ok)
            new_stage = 4'd0;
        e_eff = {1'b0, cw_min_exp} + {1'b0, new_stage};
        if (e_eff > {1'b0, cw_max_exp})
            e_eff = {1'b0, cw_max_exp};
        if (e_eff > 5'(CW_WIDTH))
            e_eff = 5'(CW_WIDTH);
        mask = '0;
        for (int b = 0; b < CW_WIDTH; b++)
            mask[b] = (b < int'(e_eff));
        draw = rnd & mask;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= DEFER;
            bo_cnt  <= '0;
            slot_us <= '0;
            stage   <= '0;
        end else if (state == TXING) begin
            if (result) begin
                stage  <= new_stage;
                bo_cnt <= draw;
                state  <= DEFER;
            end
        end else if (start) begin
            state <= TXING;
        end else if (lose) begin
            stage  <= new_stage;
            bo_cnt <= draw;
            state  <= DEFER;
        end else if (!ch_idle) begin
            state <= DEFER;
        end else begin
            case (state)
                DEFER: begin
                    if (idle_us >= aifs_us) begin
                        state   <= (bo_cnt == '0) ? READY : COUNT;
                        slot_us <= '0;
                    end
                end
                COUNT: begin
                    if (bo_cnt == '0) begin
                        state <= READY;
                    end else if (us_pulse) begin
                        if (slot_us >= slot_time - 5'd1) begin
                            bo_cnt  <= bo_cnt - 1'b1;
                            slot_us <= '0;
                        end else begin
                            slot_us <= slot_us + 5'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready = (state == READY);
endmodule

module edca_backoff #(
    parameter int NUM_QUEUE  = 4,
    parameter int CW_WIDTH   = 10,
    parameter int TIME_WIDTH = 12
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   tsf_pulse_1M,
    input  logic                   ch_idle,
    input  logic                   fcs_in_strobe,
    input  logic                   fcs_valid,
    input  logic [6:0]             sifs_time,
    input  logic [4:0]             slot_time,
    input  logic [7:0]             eifs_extra,
    input  logic [4*NUM_QUEUE-1:0] aifsn,
    input  logic [4*NUM_QUEUE-1:0] cw_min_exp,
    input  logic [4*NUM_QUEUE-1:0] cw_max_exp,
    input  logic [NUM_QUEUE-1:0]   queue_pending,
    input  logic                   tx_start,
    input  logic                   tx_result_valid,
    input  logic                   tx_result_ok,
    output logic [NUM_QUEUE-1:0]   tx_grant,
    output logic                   grant_valid,
    output logic [4*NUM_QUEUE-1:0] retry_stage
);
    localparam logic [31:0] TMAX = 32'((64'd1 << TIME_WIDTH) - 64'd1);

    logic [31:0]                 lfsr;
    logic                        eifs_flag;
    logic [TIME_WIDTH-1:0]       idle_us;
    logic [NUM_QUEUE-1:0]        ready;
    logic [NUM_QUEUE-1:0]        elig;
    logic [NUM_QUEUE-1:0]        win;
    logic [NUM_QUEUE-1:0]        lose;
    logic [NUM_QUEUE-1:0][3:0]   stage;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            lfsr <= 32'h1020f0cb;
        else
            lfsr <= {lfsr[30:0], ~(lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0])};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            eifs_flag <= 1'b0;
        else if (fcs_in_strobe)
            eifs_flag <= !fcs_valid;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            idle_us <= '0;
        else if (!ch_idle)
            idle_us <= '0;
        else if (tsf_pulse_1M && idle_us != '1)
            idle_us <= idle_us + 1'b1;
    end

    for (genvar i = 0; i < NUM_QUEUE; i++) begin : g_q
        localparam int ROT = (7 * i) % 32;
        logic [CW_WIDTH-1:0]   rnd;
        logic [3:0]            an;
        logic [31:0]           sum;
        logic [TIME_WIDTH-1:0] aifs;

        // Bit b of a left rotation by ROT comes from bit b-ROT.
        for (genvar b = 0; b < CW_WIDTH; b++) begin : g_b
            assign rnd[b] = lfsr[(b - ROT + 32) % 32];
        end

        assign an   = (aifsn[4*i +: 4] == 4'd0) ? 4'd2 : aifsn[4*i +: 4];
        assign sum  = 32'(sifs_time) + 32'(an) * 32'(slot_time)
                    + (eifs_flag ? 32'(eifs_extra) : 32'd0);
        assign aifs = (sum > TMAX) ? '1 : sum[TIME_WIDTH-1:0];

        edca_queue #(
            .CW_WIDTH  (CW_WIDTH),
            .TIME_WIDTH(TIME_WIDTH)
        ) u_queue (
            .clk       (clk),
            .rstn      (rstn),
            .us_pulse  (tsf_pulse_1M),
            .ch_idle   (ch_idle),
            .idle_us   (idle_us),
            .aifs_us   (aifs),
            .slot_time (slot_time),
            .cw_min_exp(cw_min_exp[4*i +: 4]),
            .cw_max_exp(cw_max_exp[4*i +: 4]),
            .rnd       (rnd),
            .start     (tx_start & tx_grant[i]),
            .result    (tx_result_valid),
            .result_ok (tx_result_ok),
            .lose      (lose[i]),
            .ready     (ready[i]),
            .stage     (stage[i])
        );
    end

    // Gating with ch_idle makes a busy channel drop the grant on the very next edge.
    assign elig = ready & queue_pending & {NUM_QUEUE{ch_idle}};

    always_comb begin
        win = '0;
        for (int i = 0; i < NUM_QUEUE; i++)
            if (elig[i]) begin
                win    = '0;
                win[i] = 1'b1;
            end
    end

`ifdef EDCA_VIRTUAL_COLLISION_EN
    assign lose = elig & ~win;
`else
    assign lose = '0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            tx_grant <= '0;
        else
            tx_grant <= win;
    end

    assign grant_valid = |tx_grant;
    assign retry_stage = stage;
endmodule

// File: tb/tb_edca_backoff.sv
// Randomized bench for edca_backoff: grant timing measured in us pulses against a spec-level model.
module tb_edca_backoff;
    localparam int NQ  = 4;
    localparam int CWW = 10;
    localparam int TW  = 12;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            tsf_pulse_1M = 1'b0;
    logic            ch_idle = 1'b0;
    logic            fcs_in_strobe = 1'b0;
    logic            fcs_valid = 1'b0;
    logic [6:0]      sifs_time = 7'd16;
    logic [4:0]      slot_time = 5'd9;
    logic [7:0]      eifs_extra = 8'd50;
    logic [4*NQ-1:0] aifsn = '0;
    logic [4*NQ-1:0] cw_min_exp = '0;
    logic [4*NQ-1:0] cw_max_exp = '0;
    logic [NQ-1:0]   queue_pending = '0;
    logic            tx_start = 1'b0;
    logic            tx_result_valid = 1'b0;
    logic            tx_result_ok = 1'b0;
    logic [NQ-1:0]   tx_grant;
    logic            grant_valid;
    logic [4*NQ-1:0] retry_stage;

    int          total = 0;
    int          bad = 0;
    int          stg[NQ];
    bit          eifs_m = 1'b0;
    logic [31:0] lfsr_m;

    edca_backoff #(.NUM_QUEUE(NQ), .CW_WIDTH(CWW), .TIME_WIDTH(TW)) dut (
        .clk(clk), .rstn(rstn), .tsf_pulse_1M(tsf_pulse_1M), .ch_idle(ch_idle),
        .fcs_in_strobe(fcs_in_strobe), .fcs_valid(fcs_valid), .sifs_time(sifs_time),
        .slot_time(slot_time), .eifs_extra(eifs_extra), .aifsn(aifsn),
        .cw_min_exp(cw_min_exp), .cw_max_exp(cw_max_exp), .queue_pending(queue_pending),
        .tx_start(tx_start), .tx_result_valid(tx_result_valid), .tx_result_ok(tx_result_ok),
        .tx_grant(tx_grant), .grant_valid(grant_valid), .retry_stage(retry_stage)
    );

    always #5 clk = ~clk;

    // Random source as defined: 32-bit XNOR LFSR stepping every cycle out of reset.
    always @(posedge clk or negedge rstn)
        if (!rstn) lfsr_m <= 32'h1020f0cb;
        else       lfsr_m <= {lfsr_m[30:0], ~(lfsr_m[31] ^ lfsr_m[21] ^ lfsr_m[1] ^ lfsr_m[0])};

    initial begin
        #900000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic us_step();
        tsf_pulse_1M = 1'b1;
        tick();
        tsf_pulse_1M = 1'b0;
        repeat (3) tick();
    endtask

    function automatic int aifs_m(input int q);
        int a, s;
        a = int'(aifsn[4*q +: 4]);
        if (a == 0) a = 2;
        s = int'(sifs_time) + a * int'(slot_time) + (eifs_m ? int'(eifs_extra) : 0);
        return (s > 4095) ? 4095 : s;
    endfunction

    function automatic int draw_m(input int q, input int stage);
        int e, sh;
        logic [31:0] r;
        e = int'(cw_min_exp[4*q +: 4]) + stage;
        if (e > int'(cw_max_exp[4*q +: 4])) e = int'(cw_max_exp[4*q +: 4]);
        if (e > CWW) e = CWW;
        sh = (7 * q) % 32;
        r = (sh == 0) ? lfsr_m : ((lfsr_m << sh) | (lfsr_m >> (32 - sh)));
        return int'(r % (32'd1 << e));
    endfunction

    task automatic do_reset();
        rstn = 1'b0;
        ch_idle = 1'b1;
        repeat (2) tick();
        foreach (stg[i]) stg[i] = 0;
        eifs_m = 1'b0;
        chk("rst_grant", tx_grant, 0);
        chk("rst_valid", grant_valid, 0);
        chk("rst_stage", retry_stage, 0);
        rstn = 1'b1;
    endtask

    // Counts us pulses from the start of an idle period until the grant shows up.
    task automatic measure(input int q, input int exp);
        int n = 0;
        while (!grant_valid && n < exp + 50) begin
            us_step();
            n++;
        end
        chk("grant_us", n, exp);
        chk("grant_vec", tx_grant, longint'(1) << q);
    endtask

    // ev: 0 no rx event, 1 bad FCS, 2 good FCS (delivered while the channel is busy).
    task automatic do_round(input int q, input bit ok, input int ev, input bit intr);
        int bo, a, exp, c, rem;
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
        tick();
        chk("grant_drop", grant_valid, 0);
        ch_idle = 1'b0;
        tick();
        if (ev != 0) begin
            fcs_in_strobe = 1'b1;
            fcs_valid = (ev == 2);
            tick();
            fcs_in_strobe = 1'b0;
            eifs_m = (ev == 1);
        end
        stg[q] = ok ? 0 : ((stg[q] == 15) ? 15 : stg[q] + 1);
        bo = draw_m(q, stg[q]);
        tx_result_valid = 1'b1;
        tx_result_ok = ok;
        tick();
        tx_result_valid = 1'b0;
        chk("stage", retry_stage[4*q +: 4], stg[q]);
        tick();
        ch_idle = 1'b1;
        a = aifs_m(q);
        exp = a + bo * int'(slot_time);
        if (intr && exp > 1) begin
            c = int'($urandom_range(exp - 1, 1));
            repeat (c) us_step();
            chk("early_grant", grant_valid, 0);
            ch_idle = 1'b0;
            us_step();
            us_step();
            ch_idle = 1'b1;
            rem = (c <= a) ? bo : bo - (c - a) / int'(slot_time);
            exp = a + rem * int'(slot_time);
        end
        measure(q, exp);
    endtask

    initial begin
        aifsn = {4'd3, 4'd4, 4'd2, 4'd0};
        queue_pending = 4'b0001;
        do_reset();
        measure(0, 34);
        do_round(0, 1'b1, 1, 1'b0);
        do_round(0, 1'b1, 2, 1'b0);

        cw_min_exp[3:0] = 4'd4;
        cw_max_exp[3:0] = 4'd6;
        repeat (4) do_round(0, 1'b0, 0, 1'b0);
        chk("stage4", retry_stage[3:0], 4);
        do_round(0, 1'b1, 0, 1'b0);

        for (int r = 0; r < 12; r++) begin
            cw_min_exp[3:0] = 4'($urandom_range(3, 0));
            cw_max_exp[3:0] = 4'($urandom_range(5, 0));
            slot_time = 5'($urandom_range(12, 1));
            sifs_time = 7'($urandom_range(30, 10));
            do_round(0, 1'($urandom_range(1, 0)), int'($urandom_range(2, 0)), 1'b1);
        end

        // Two queues become READY on the same edge.
        sifs_time = 7'd16;
        slot_time = 5'd9;
        aifsn = {4'd2, 4'd4, 4'd2, 4'd0};
        cw_min_exp = 16'h0020;
        cw_max_exp = 16'h0050;
        queue_pending = 4'b1010;
        do_reset();
        measure(3, 34);
`ifdef EDCA_VIRTUAL_COLLISION_EN
        chk("vc_stage", retry_stage[7:4], 1);
`else
        chk("vc_stage", retry_stage[7:4], 0);
`endif
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
        tick();
`ifndef EDCA_VIRTUAL_COLLISION_EN
        chk("next_grant", tx_grant, 4'b0010);
`endif

        // Asynchronous reset while q3 is transmitting.
        #2;
        rstn = 1'b0;
        #1;
        chk("async_grant", tx_grant, 0);
        chk("async_valid", grant_valid, 0);
        chk("async_stage", retry_stage, 0);
        tick();
        aifsn = {4'd2, 4'd4, 4'd5, 4'd0};
        queue_pending = 4'b0010;
        foreach (stg[i]) stg[i] = 0;
        eifs_m = 1'b0;
        rstn = 1'b1;
        measure(1, 61);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
